// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - ALU control codes, RV32I opcodes and the issue record shared by decode and issue
// Purpose: shared definitions for the alu_issue slice.
// Ports: none (package).
package alu_pkg;

  // 4-bit ALU control codes understood by the downstream ALU.
  typedef enum logic [3:0] {
    CTL_ADD  = 4'b0000,
    CTL_SUB  = 4'b0001,
    CTL_SUBU = 4'b0010,
    CTL_SLL  = 4'b0101,
    CTL_SRL  = 4'b0110,
    CTL_SRA  = 4'b0111,
    CTL_SLT  = 4'b1001,
    CTL_SLTU = 4'b1010,
    CTL_AND  = 4'b1100,
    CTL_OR   = 4'b1101,
    CTL_XOR  = 4'b1110,
    CTL_NOR  = 4'b1111
  } alu_ctl_e;

  // RV32I major opcodes handled by this stage.
  typedef enum logic [6:0] {
    OPC_OP     = 7'b0110011,
    OPC_OP_IMM = 7'b0010011,
    OPC_LUI    = 7'b0110111,
    OPC_AUIPC  = 7'b0010111,
    OPC_BRANCH = 7'b1100011
  } rv_opcode_e;

  // Decoded op as held in the output register and the skid entry.
  typedef struct packed {
    logic [31:0] da;
    logic [31:0] db;
    logic [3:0]  ctl;
    logic [4:0]  rd;
    logic        we;
    logic        branch;
    logic [2:0]  bfunct3;
    logic        illegal;
  } issue_t;

endpackage

// File: rtl/alu_decode.sv
// rtl/alu_decode.sv - combinational RV32I decode into ALU control, operands and writeback metadata
// Purpose: map one instruction plus PC/register values onto an issue_t record.
// Ports: i_instr (instruction word), i_pc (its PC), i_rs1/i_rs2 (register values),
//        o_dec (decoded issue record; illegal ops come out zeroed with illegal=1).
module alu_decode
  import alu_pkg::*;
(
  input  logic [31:0] i_instr,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_rs1,
  input  logic [31:0] i_rs2,
  output issue_t      o_dec
);

  logic [6:0]  w_opcode;
  logic [2:0]  w_funct3;
  logic [6:0]  w_funct7;
  logic [4:0]  w_rd_field;
  logic [31:0] w_imm_i;
  logic [31:0] w_imm_u;
  logic        w_is_op;
  logic        w_f7_zero;
  logic        w_f7_alt;

  logic        w_legal;
  logic [3:0]  w_ctl;
  logic [31:0] w_da;
  logic [31:0] w_db;
  logic [4:0]  w_rd;
  logic        w_we;
  logic        w_branch;
  logic [2:0]  w_bf3;

  assign w_opcode   = i_instr[6:0];
  assign w_rd_field = i_instr[11:7];
  assign w_funct3   = i_instr[14:12];
  assign w_funct7   = i_instr[31:25];
  assign w_imm_i    = {{20{i_instr[31]}}, i_instr[31:20]};
  assign w_imm_u    = {i_instr[31:12], 12'b0};
  assign w_is_op    = (w_opcode == OPC_OP);
  assign w_f7_zero  = (w_funct7 == 7'b0000000);
  assign w_f7_alt   = (w_funct7 == 7'b0100000);

  always_comb begin
    w_legal  = 1'b1;
    w_ctl    = CTL_ADD;
    w_da     = '0;
    w_db     = '0;
    w_rd     = '0;
    w_we     = 1'b0;
    w_branch = 1'b0;
    w_bf3    = '0;
    case (w_opcode)
      OPC_OP, OPC_OP_IMM: begin
        w_da = i_rs1;
        // Immediate shifts keep the full sign-extended imm; the ALU only looks at db[4:0].
        w_db = w_is_op ? i_rs2 : w_imm_i;
        w_rd = w_rd_field;
        w_we = (w_rd_field != 5'd0);
        // funct7 matters for every OP form but only for the shift forms of OP-IMM.
        case (w_funct3)
          3'b000: begin
            w_ctl   = (w_is_op && w_f7_alt) ? CTL_SUB : CTL_ADD;
            w_legal = !w_is_op || w_f7_zero || w_f7_alt;
          end
          3'b001: begin
            w_ctl   = CTL_SLL;
            w_legal = w_f7_zero;
          end
          3'b010: begin
            w_ctl   = CTL_SLT;
            w_legal = !w_is_op || w_f7_zero;
          end
          3'b011: begin
            w_ctl   = CTL_SLTU;
            w_legal = !w_is_op || w_f7_zero;
          end
          3'b100: begin
            w_ctl   = CTL_XOR;
            w_legal = !w_is_op || w_f7_zero;
          end
          3'b101: begin
            w_ctl   = w_f7_alt ? CTL_SRA : CTL_SRL;
            w_legal = w_f7_zero || w_f7_alt;
          end
          3'b110: begin
            w_ctl   = CTL_OR;
            w_legal = !w_is_op || w_f7_zero;
          end
          default: begin
            w_ctl   = CTL_AND;
            w_legal = !w_is_op || w_f7_zero;
          end
        endcase
      end
      OPC_LUI: begin
        w_db = w_imm_u;
        w_rd = w_rd_field;
        w_we = (w_rd_field != 5'd0);
      end
      OPC_AUIPC: begin
        w_da = i_pc;
        w_db = w_imm_u;
        w_rd = w_rd_field;
        w_we = (w_rd_field != 5'd0);
      end
      OPC_BRANCH: begin
        w_da     = i_rs1;
        w_db     = i_rs2;
        w_branch = 1'b1;
        w_bf3    = w_funct3;
        // BEQ/BNE resolve on the ALU zero flag, hence the non-trapping SUBU.
        case (w_funct3)
          3'b000, 3'b001: w_ctl = CTL_SUBU;
          3'b100, 3'b101: w_ctl = CTL_SLT;
          3'b110, 3'b111: w_ctl = CTL_SLTU;
          default:        w_legal = 1'b0;
        endcase
      end
      default: w_legal = 1'b0;
    endcase
  end

  // Illegal ops still issue so downstream can trap, but carry no operands or side effects.
  always_comb begin
    o_dec         = '0;
    o_dec.illegal = 1'b1;
    if (w_legal) begin
      o_dec.da      = w_da;
      o_dec.db      = w_db;
      o_dec.ctl     = w_ctl;
      o_dec.rd      = w_rd;
      o_dec.we      = w_we;
      o_dec.branch  = w_branch;
      o_dec.bfunct3 = w_bf3;
      o_dec.illegal = 1'b0;
    end
  end

endmodule

// File: rtl/alu_issue.sv
// rtl/alu_issue.sv - decode-and-issue stage with registered output, one-entry skid and issue counter
// Purpose: accept one instruction per cycle, decode it and present it to the ALU one cycle later.
// Ports: clk/rst (async active-high), in_valid/in_ready + in_instr/in_pc/in_rs1/in_rs2 (upstream),
//        out_valid/out_ready + out_da/out_db/out_ctl/out_rd/out_we/out_branch/out_bfunct3/out_illegal
//        (downstream), issue_count (completed output handshakes, wrapping).
module alu_issue
  import alu_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic [31:0] in_rs1,
  input  logic [31:0] in_rs2,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_da,
  output logic [31:0] out_db,
  output logic [3:0]  out_ctl,
  output logic [4:0]  out_rd,
  output logic        out_we,
  output logic        out_branch,
  output logic [2:0]  out_bfunct3,
  output logic        out_illegal,
  output logic [31:0] issue_count
);

  issue_t      w_dec;
  issue_t      r_out;
  issue_t      r_skid;
  logic        r_out_valid;
  logic        r_skid_valid;
  logic [31:0] r_issue_count;
  logic        w_in_fire;
  logic        w_out_fire;
  logic        w_out_load;

  alu_decode u_decode (
    .i_instr (in_instr),
    .i_pc    (in_pc),
    .i_rs1   (in_rs1),
    .i_rs2   (in_rs2),
    .o_dec   (w_dec)
  );

  // Ready depends only on skid occupancy, so a full skid blocks input for exactly the drain cycle.
  assign in_ready   = ~rst & ~r_skid_valid;
  assign w_in_fire  = in_valid & in_ready;
  assign w_out_fire = r_out_valid & out_ready;
  assign w_out_load = ~r_out_valid | out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out        <= '0;
      r_out_valid  <= 1'b0;
      r_skid       <= '0;
      r_skid_valid <= 1'b0;
    end else if (w_out_load) begin
      // Skid entry is older than anything at the input, so it goes first.
      if (r_skid_valid) begin
        r_out        <= r_skid;
        r_out_valid  <= 1'b1;
        r_skid_valid <= 1'b0;
      end else if (w_in_fire) begin
        r_out       <= w_dec;
        r_out_valid <= 1'b1;
      end else begin
        r_out_valid <= 1'b0;
      end
    end else if (w_in_fire) begin
      r_skid       <= w_dec;
      r_skid_valid <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_issue_count <= '0;
    end else if (w_out_fire) begin
      r_issue_count <= r_issue_count + 32'd1;
    end
  end

  assign out_valid   = r_out_valid;
  assign out_da      = r_out.da;
  assign out_db      = r_out.db;
  assign out_ctl     = r_out.ctl;
  assign out_rd      = r_out.rd;
  assign out_we      = r_out.we;
  assign out_branch  = r_out.branch;
  assign out_bfunct3 = r_out.bfunct3;
  assign out_illegal = r_out.illegal;
  assign issue_count = r_issue_count;

endmodule

// File: tb/tb_alu_issue.sv
// tb/tb_alu_issue.sv - self-checking bench for alu_issue: decode table, backpressure, reset, counter wrap
module tb_alu_issue;
  import alu_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic [31:0] in_rs1;
  logic [31:0] in_rs2;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_da;
  logic [31:0] out_db;
  logic [3:0]  out_ctl;
  logic [4:0]  out_rd;
  logic        out_we;
  logic        out_branch;
  logic [2:0]  out_bfunct3;
  logic        out_illegal;
  logic [31:0] issue_count;

  alu_issue dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_instr    (in_instr),
    .in_pc       (in_pc),
    .in_rs1      (in_rs1),
    .in_rs2      (in_rs2),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_da      (out_da),
    .out_db      (out_db),
    .out_ctl     (out_ctl),
    .out_rd      (out_rd),
    .out_we      (out_we),
    .out_branch  (out_branch),
    .out_bfunct3 (out_bfunct3),
    .out_illegal (out_illegal),
    .issue_count (issue_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1;
    logic [31:0] rs2;
    issue_t      exp;
  } vec_t;

  localparam int NVEC = 21;
  vec_t   vecs [NVEC];
  issue_t sb [$];
  int     n_pass = 0;
  int     n_total = 0;

  function automatic issue_t mk(input logic [31:0] da, input logic [31:0] db, input logic [3:0] ctl,
                                input logic [4:0] rd, input logic we, input logic br,
                                input logic [2:0] bf3, input logic ill);
    issue_t r;
    r.da = da; r.db = db; r.ctl = ctl; r.rd = rd; r.we = we;
    r.branch = br; r.bfunct3 = bf3; r.illegal = ill;
    return r;
  endfunction

  task automatic chk(input string nm, input logic [78:0] got, input logic [78:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, got, exp);
  endtask

  // Scoreboard side: every output handshake must match the oldest accepted op.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (sb.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_issue: got ctl=%h da=%h with empty scoreboard", out_ctl, out_da);
      end else begin
        chk("issue", {out_da, out_db, out_ctl, out_rd, out_we, out_branch, out_bfunct3, out_illegal},
            sb.pop_front());
      end
    end
  end

  task automatic drive(input int i);
    in_valid = 1'b1;
    in_instr = vecs[i].instr;
    in_pc    = vecs[i].pc;
    in_rs1   = vecs[i].rs1;
    in_rs2   = vecs[i].rs2;
  endtask

  // Called at posedge+#1; returns at posedge+#1 after the accepting edge.
  task automatic send(input int i);
    int n = 0;
    drive(i);
    while (!in_ready && n < 50) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) begin
      n_total++;
      $display("FAIL send_timeout: in_ready stayed 0 for vector %0d", i);
    end else begin
      sb.push_back(vecs[i].exp);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 100) begin
      @(posedge clk); n++;
    end
    #1;
    chk("drain_empty", sb.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h402081B3, 32'h0, 32'h5,        32'h7,  mk(32'h5, 32'h7, CTL_SUB, 5'd3, 1, 0, 3'd0, 0)};
    vecs[1]  = '{32'h407352B3, 32'h0, 32'h80000000, 32'h4,  mk(32'h80000000, 32'h4, CTL_SRA, 5'd5, 1, 0, 3'd0, 0)};
    vecs[2]  = '{32'hFFF00093, 32'h0, 32'h11,       32'h22, mk(32'h11, 32'hFFFFFFFF, CTL_ADD, 5'd1, 1, 0, 3'd0, 0)};
    vecs[3]  = '{32'h12345137, 32'h0, 32'hAA,       32'hBB, mk(32'h0, 32'h12345000, CTL_ADD, 5'd2, 1, 0, 3'd0, 0)};
    vecs[4]  = '{32'h00001217, 32'h80000000, 32'h1, 32'h2, mk(32'h80000000, 32'h1000, CTL_ADD, 5'd4, 1, 0, 3'd0, 0)};
    vecs[5]  = '{32'h0020E463, 32'h0, 32'h3,        32'h9,  mk(32'h3, 32'h9, CTL_SLTU, 5'd0, 0, 1, 3'd6, 0)};
    vecs[6]  = '{32'h00000000, 32'h40, 32'h1234,    32'h5678, mk(32'h0, 32'h0, CTL_ADD, 5'd0, 0, 0, 3'd0, 1)};
    vecs[7]  = '{32'h022081B3, 32'h0, 32'h1,        32'h2,  mk(32'h0, 32'h0, CTL_ADD, 5'd0, 0, 0, 3'd0, 1)};
    vecs[8]  = '{32'h00208463, 32'h0, 32'h4,        32'h4,  mk(32'h4, 32'h4, CTL_SUBU, 5'd0, 0, 1, 3'd0, 0)};
    vecs[9]  = '{32'h0020C463, 32'h0, 32'h4,        32'h8,  mk(32'h4, 32'h8, CTL_SLT, 5'd0, 0, 1, 3'd4, 0)};
    vecs[10] = '{32'h0020A463, 32'h0, 32'h4,        32'h8,  mk(32'h0, 32'h0, CTL_ADD, 5'd0, 0, 0, 3'd0, 1)};
    vecs[11] = '{32'h00331293, 32'h0, 32'hF0,       32'h1,  mk(32'hF0, 32'h3, CTL_SLL, 5'd5, 1, 0, 3'd0, 0)};
    vecs[12] = '{32'h40435293, 32'h0, 32'hF0,       32'h1,  mk(32'hF0, 32'h404, CTL_SRA, 5'd5, 1, 0, 3'd0, 0)};
    vecs[13] = '{32'h00208033, 32'h0, 32'h1,        32'h2,  mk(32'h1, 32'h2, CTL_ADD, 5'd0, 0, 0, 3'd0, 0)};
    vecs[14] = '{32'h8000C393, 32'h0, 32'hFF,       32'h0,  mk(32'hFF, 32'hFFFFF800, CTL_XOR, 5'd7, 1, 0, 3'd0, 0)};
    vecs[15] = '{32'h40331293, 32'h0, 32'hF0,       32'h1,  mk(32'h0, 32'h0, CTL_ADD, 5'd0, 0, 0, 3'd0, 1)};
    vecs[16] = '{32'h003160B3, 32'h0, 32'hC,        32'h3,  mk(32'hC, 32'h3, CTL_OR, 5'd1, 1, 0, 3'd0, 0)};
    vecs[17] = '{32'h003130B3, 32'h0, 32'hC,        32'h3,  mk(32'hC, 32'h3, CTL_SLTU, 5'd1, 1, 0, 3'd0, 0)};
    vecs[18] = '{32'h0000006F, 32'h0, 32'h7,        32'h7,  mk(32'h0, 32'h0, CTL_ADD, 5'd0, 0, 0, 3'd0, 1)};
    vecs[19] = '{32'h007352B3, 32'h0, 32'h8,        32'h1,  mk(32'h8, 32'h1, CTL_SRL, 5'd5, 1, 0, 3'd0, 0)};
    vecs[20] = '{32'h003170B3, 32'h0, 32'hF0F0,     32'hFF, mk(32'hF0F0, 32'hFF, CTL_AND, 5'd1, 1, 0, 3'd0, 0)};

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs1 = '0; in_rs2 = '0;
    out_ready = 1'b1;

    // Reset state.
    #12;
    chk("reset_out_valid", out_valid, 0);
    chk("reset_in_ready", in_ready, 0);
    chk("reset_issue_count", issue_count, 0);
    chk("reset_out_da", out_da, 0);
    @(negedge clk); rst = 1'b0; #1;
    chk("release_in_ready", in_ready, 1);

    // Decode table, full throughput.
    @(posedge clk); #1;
    for (int i = 0; i < NVEC; i++) send(i);
    drain();
    chk("table_issue_count", issue_count, NVEC);

    // Reset mid-stream with output valid and skid full.
    @(posedge clk); #1;
    out_ready = 1'b0;
    drive(0);
    @(posedge clk); #1;
    drive(1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("pre_reset_out_valid", out_valid, 1);
    chk("pre_reset_skid_full", in_ready, 0);
    #2 rst = 1'b1; #1;
    chk("midreset_out_valid", out_valid, 0);
    chk("midreset_in_ready", in_ready, 0);
    chk("midreset_issue_count", issue_count, 0);
    chk("midreset_out_ctl", out_ctl, 0);
    chk("midreset_out_db", out_db, 0);
    out_ready = 1'b1;
    @(negedge clk); rst = 1'b0; #1;
    chk("midrelease_in_ready", in_ready, 1);
    @(posedge clk); #1;
    chk("midrelease_no_ghost", out_valid, 0);

    // Backpressure: four ops, out_ready low for three cycles.
    out_ready = 1'b0;
    drive(0);
    sb.push_back(vecs[0].exp);
    @(posedge clk); #1;
    chk("bp_ready_after_1st", in_ready, 1);
    drive(1);
    sb.push_back(vecs[1].exp);
    @(posedge clk); #1;
    chk("bp_ready_drop", in_ready, 0);
    drive(2);
    @(posedge clk); #1;
    chk("bp_hold_da", out_da, vecs[0].exp.da);
    chk("bp_hold_ctl", out_ctl, vecs[0].exp.ctl);
    chk("bp_still_blocked", in_ready, 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_ready_rise", in_ready, 1);
    sb.push_back(vecs[2].exp);
    @(posedge clk); #1;
    drive(3);
    sb.push_back(vecs[3].exp);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(posedge clk); #1;
    chk("bp_sb_empty", sb.size(), 0);
    chk("bp_out_valid_fall", out_valid, 0);
    chk("bp_issue_count", issue_count, 4);

    // Counter wrap.
    @(posedge clk); #1;
    force dut.r_issue_count = 32'hFFFFFFFF;
    #1 release dut.r_issue_count;
    #1;
    chk("wrap_preset", issue_count, 32'hFFFFFFFF);
    @(posedge clk); #1;
    send(16);
    drain();
    chk("wrap_issue_count", issue_count, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/alu_issue.md
# alu_issue

Decode-and-issue stage that sits directly in front of the 32-bit ALU. It accepts one RV32I instruction per cycle with its PC and register operands over a valid/ready handshake. It decodes the instruction into the ALU's 4-bit control code and its two operands, and presents them through a registered output with a one-entry skid buffer. It also supplies the destination/write-enable and branch metadata needed by writeback and branch resolution.

## Interface
- No parameters; data width fixed at 32, control width at 4.
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  upstream has an instruction.
- in_ready  out  1  stage can accept; equals ~rst & ~skid_valid.
- in_instr  in  32  RV32I instruction word.
- in_pc  in  32  instruction PC.
- in_rs1  in  32  rs1 register value.
- in_rs2  in  32  rs2 register value.
- out_valid  out  1  issued op valid.
- out_ready  in  1  ALU/downstream accepts.
- out_da  out  32  ALU operand A.
- out_db  out  32  ALU operand B.
- out_ctl  out  4  ALU control code.
- out_rd  out  5  destination register.
- out_we  out  1  register write enable; 0 when rd==0.
- out_branch  out  1  op is a conditional branch.
- out_bfunct3  out  3  branch funct3, passed through for resolution.
- out_illegal  out  1  instruction not decoded.
- issue_count  out  32  count of out handshakes.

## Operation
- ALU control codes are fixed:
  - ADD 0000, SUB 0001, SUBU 0010.
  - SLL 0101, SRL 0110, SRA 0111.
  - SLT 1001, SLTU 1010.
  - AND 1100, OR 1101, XOR 1110, NOR 1111.
- OP (0110011): da=rs1, db=rs2.
  - funct3 000 gives ADD when funct7=0000000 and SUB when funct7=0100000.
  - funct3 001 gives SLL, 010 gives SLT, 011 gives SLTU, 100 gives XOR, 110 gives OR, 111 gives AND.
  - funct3 101 gives SRL when funct7=0000000 and SRA when funct7=0100000.
  - Any other funct7 is illegal.
- OP-IMM (0010011): same mapping with da=rs1 and db=sign-extended I-immediate.
  - funct7 is checked only for funct3 001 and 101.
  - For shifts, db carries sign-extended imm; the ALU uses db[4:0].
- LUI (0110111): da=0, db={instr[31:12],12'b0}, ctl=ADD.
- AUIPC (0010111): da=pc, db=U-immediate, ctl=ADD.
- BRANCH (1100011): da=rs1, db=rs2, out_branch=1, out_we=0, out_rd=0.
  - funct3 000/001 give SUBU; resolution uses the ALU zero flag.
  - funct3 100/101 give SLT.
  - funct3 110/111 give SLTU.
  - funct3 010/011 are illegal.
- Any other opcode, or an illegal combination:
  - out_illegal=1, ctl=ADD, da=db=0, out_we=0, out_branch=0.
  - The op is still issued so downstream can trap.
- Decode is combinational on the input side. Decoded fields, not raw instructions, are stored in the output register and the skid entry.
- issue_count increments on every out_valid&&out_ready and wraps 0xFFFFFFFF→0.

## Timing
- Latency: one cycle from input handshake to out_valid. Throughput is one op per cycle while out_ready=1.
- Reset (async, any cycle, including mid-transfer):
  - out_valid=0, skid_valid=0, issue_count=0.
  - All data outputs are 0 and in_ready=0.
  - In-flight ops are discarded.
- After reset deasserts, in_ready=1 in the same cycle.
- Output register loads when it is empty or out_ready=1. Source priority: skid entry if valid, else the accepted input.
- Output stall:
  - While out_valid=1 and out_ready=0, all out_* fields hold stable.
  - A beat accepted in the same cycle goes into the skid entry, and in_ready drops next cycle.
- Skid full with out_ready=1: the skid entry moves to the output and in_ready rises next cycle. No input is accepted that cycle because in_ready=0.
- If there is no accepted input and out_ready=1, out_valid falls next cycle.
- Ordering is strictly FIFO. No op is dropped or duplicated.

## Structure
- Package alu_pkg holds:
  - the 4-bit ALU control constants above;
  - RV32I opcode constants;
  - a packed issue_t struct {da, db, ctl, rd, we, branch, bfunct3, illegal}.
- Sub-module alu_decode is purely combinational: instr, pc, rs1, rs2 → issue_t.
- alu_issue holds the output register, the skid register and the counter.

## Test plan
- Reset mid-stream:
  - Stimulus: assert rst while out_valid=1 and the skid is full.
  - Required: out_valid=0, issue_count=0 and in_ready=0 immediately; in_ready=1 after release.
- Register ALU ops:
  - `sub x3,x1,x2` (0x402081B3) with rs1=5, rs2=7 → next cycle ctl=0001, da=5, db=7, rd=3, we=1.
  - `sra x5,x6,x7` (0x407352B3) → ctl=0111.
- Immediate forms:
  - `addi x1,x0,-1` (0xFFF00093) → db=0xFFFFFFFF, ctl=0000.
  - `lui x2,0x12345` (0x12345137) → da=0, db=0x12345000.
  - `auipc` at pc=0x80000000 → da=0x80000000.
- Branch and illegal:
  - `bltu` (funct3 110) → ctl=1010, out_branch=1, we=0.
  - 0x00000000 → out_illegal=1, da=db=0.
  - `add` with funct7=0000001 → out_illegal=1.
- Backpressure:
  - Stimulus: stream 4 ops with out_ready held 0 for 3 cycles, then 1.
  - Required: in_ready drops after the 2nd accept; ops emerge in order 1,2,3,4; issue_count=4.
- Counter wrap: force issue_count=0xFFFFFFFF, complete one handshake → issue_count=0.
